// File: rtl/sensor_conditioner_pkg.sv
// Shared lane definitions for the vehicle sensor path and the traffic controller.
// Also holds the counter-width helper used by every parameter-sized counter.
package sensor_conditioner_pkg;

  localparam int NUM_LANES = 8;

  typedef enum logic [2:0] {
    LANE_ESS = 3'd0,
    LANE_ELS = 3'd1,
    LANE_WSS = 3'd2,
    LANE_WLS = 3'd3,
    LANE_NSS = 3'd4,
    LANE_NLS = 3'd5,
    LANE_SSS = 3'd6,
    LANE_SLS = 3'd7
  } lane_e;

  // Width of a counter spanning 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// One lane: 2-flop synchronizer, debounce counter, stable level and latched
// vehicle request that is held until the controller serves the lane.
module sensor_debounce
  import sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYC = 4
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic raw,
  input  logic serve,
  output logic present,
  output logic req
);

  localparam int             CW       = cnt_w(DEB_CYC);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYC - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;
  logic          present_d;
  logic          req_d;

  // Synchronizer stage: raw is sampled nowhere else
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce stage: count consecutive disagreeing cycles, adopt on the last one
  always_comb begin
    cnt_d     = '0;
    present_d = present;
    if (sync_p1 != present) begin
      if (cnt == CNT_LAST) begin
        present_d = sync_p1;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
    // New present is used so the request rises together with present (set wins)
    req_d = present_d | (req & ~serve);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      present <= 1'b0;
      req     <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      present <= present_d;
      req     <= req_d;
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the eight raw vehicle sensors into stable levels and latched
// requests, and generates the controller's timer step-enable tick.
module sensor_conditioner
  import sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYC  = 4,
  parameter int TICK_DIV = 12000000
) (
  input  logic                 clk_in,
  input  logic                 reset_n,
  input  logic [NUM_LANES-1:0] sensor_raw,
  input  logic [NUM_LANES-1:0] serve,
  output logic [NUM_LANES-1:0] present,
  output logic [NUM_LANES-1:0] req,
  output logic                 tick
);

  localparam int            TW        = cnt_w(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sensor_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_deb (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .raw     (sensor_raw[i]),
      .serve   (serve[i]),
      .present (present[i]),
      .req     (req[i])
    );
  end

  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_cnt_d;

  always_comb begin
    tick_cnt_d = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
  end

  // tick is registered but lines up exactly with tick_cnt == TICK_DIV-1
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else begin
      tick_cnt <= tick_cnt_d;
      tick     <= (tick_cnt_d == TICK_LAST);
    end
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Bench for sensor_conditioner: directed vector table, hand sequences for
// tick timing and reset, then random traffic against a windowed reference model.
module tb_sensor_conditioner;

  localparam int DEB = 4;
  localparam int TDIV = 10;

  logic       clk_in = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] sensor_raw = '0;
  logic [7:0] serve = '0;
  logic [7:0] present;
  logic [7:0] req;
  logic       tick;

  int checks = 0;
  int failures = 0;

  sensor_conditioner #(
    .DEB_CYC  (DEB),
    .TICK_DIV (TDIV)
  ) dut (
    .clk_in     (clk_in),
    .reset_n    (reset_n),
    .sensor_raw (sensor_raw),
    .serve      (serve),
    .present    (present),
    .req        (req),
    .tick       (tick)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [7:0] raw;
    logic [7:0] srv;
    int         hold;
    logic [7:0] exp_pres;
    logic [7:0] exp_req;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reset is released on a falling edge so the next rising edge is clock 1.
  task automatic do_reset();
    @(negedge clk_in);
    reset_n = 1'b0;
    sensor_raw = '0;
    serve = '0;
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;
  endtask

  // Reference model state: present flips once the last DEB synchronized samples
  // (raw delayed by two clocks) all disagree with it.
  logic [7:0] raw_at[32];
  logic [7:0] m_pres, m_req;
  logic       m_tick;
  int         e;

  function automatic logic sync_sample(input int idx, input int lane);
    if (idx < 3) return 1'b0;
    return raw_at[(idx - 2) % 32][lane];
  endfunction

  task automatic model_clear();
    e = 0;
    m_pres = '0;
    m_req = '0;
    m_tick = 1'b0;
    for (int k = 0; k < 32; k++) raw_at[k] = '0;
  endtask

  task automatic model_edge(input logic [7:0] rv, input logic [7:0] sv);
    e++;
    raw_at[e % 32] = rv;
    for (int i = 0; i < 8; i++) begin
      logic flip;
      flip = 1'b1;
      for (int k = 0; k < DEB; k++)
        if (sync_sample(e - k, i) == m_pres[i]) flip = 1'b0;
      if (flip) m_pres[i] = ~m_pres[i];
    end
    for (int i = 0; i < 8; i++) begin
      if (m_pres[i])   m_req[i] = 1'b1;
      else if (sv[i])  m_req[i] = 1'b0;
    end
    m_tick = ((e + 1) % TDIV) == 0;
  endtask

  initial begin
    // Asynchronous reset state, before any clock edge
    #2 reset_n = 1'b0;
    #1;
    check("reset_present", present, 8'h00);
    check("reset_req", req, 8'h00);
    check("reset_tick", tick, 1'b0);
    repeat (2) @(negedge clk_in);
    reset_n = 1'b1;

    // Idle: levels stay low, tick seen by clocks 10, 20, 30
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check($sformatf("idle_tick_c%0d", c), tick, ((c + 1) % TDIV) == 0);
      check($sformatf("idle_levels_c%0d", c), {present, req}, 16'h0000);
    end

    // Directed vectors: inputs held for 'hold' clocks, serve only in the first
    do_reset();
    tbl.push_back('{8'h00, 8'h00, 3, 8'h00, 8'h00});
    tbl.push_back('{8'h01, 8'h00, 4, 8'h00, 8'h00});
    tbl.push_back('{8'h01, 8'h00, 3, 8'h01, 8'h01});
    tbl.push_back('{8'h11, 8'h00, 3, 8'h01, 8'h01});
    tbl.push_back('{8'h01, 8'h00, 8, 8'h01, 8'h01});
    tbl.push_back('{8'h05, 8'h00, 7, 8'h05, 8'h05});
    tbl.push_back('{8'h05, 8'h04, 1, 8'h05, 8'h05});
    tbl.push_back('{8'h01, 8'h00, 7, 8'h01, 8'h05});
    tbl.push_back('{8'h01, 8'h04, 1, 8'h01, 8'h01});
    tbl.push_back('{8'h01, 8'h10, 1, 8'h01, 8'h01});
    tbl.push_back('{8'hFF, 8'h00, 5, 8'h01, 8'h01});
    tbl.push_back('{8'hFF, 8'h00, 1, 8'hFF, 8'hFF});
    tbl.push_back('{8'h00, 8'hFF, 7, 8'h00, 8'hFF});
    tbl.push_back('{8'h00, 8'hFE, 1, 8'h00, 8'h01});
    tbl.push_back('{8'h00, 8'h01, 1, 8'h00, 8'h00});
    for (int r = 0; r < tbl.size(); r++) begin
      sensor_raw = tbl[r].raw;
      serve = tbl[r].srv;
      for (int c = 0; c < tbl[r].hold; c++) begin
        @(posedge clk_in);
        @(negedge clk_in);
        serve = '0;
      end
      check($sformatf("vec%0d_present", r), present, tbl[r].exp_pres);
      check($sformatf("vec%0d_req", r), req, tbl[r].exp_req);
    end

    // Reset mid-debounce with the tick counter at 7
    do_reset();
    sensor_raw = 8'h01;
    repeat (3) @(negedge clk_in);
    sensor_raw = 8'hFF;
    repeat (4) @(negedge clk_in);
    check("pre_reset_present", present, 8'h01);
    check("pre_reset_req", req, 8'h01);
    #1 reset_n = 1'b0;
    #1;
    check("midrst_present", present, 8'h00);
    check("midrst_req", req, 8'h00);
    check("midrst_tick", tick, 1'b0);
    @(negedge clk_in);
    reset_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      check($sformatf("postrst_tick_c%0d", c), tick, c == 9);
      if (c == 5) check("postrst_present_c5", present, 8'h00);
      if (c == 6) check("postrst_present_c6", present, 8'hFF);
    end

    // Random traffic against the reference model, with occasional resets
    do_reset();
    model_clear();
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] rv, sv;
      check("rand_outputs", {m_pres, m_req, m_tick}, {present, req, tick});
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        #1;
        check("rand_reset", {present, req, tick}, 17'h0);
        @(negedge clk_in);
        reset_n = 1'b1;
        model_clear();
        continue;
      end
      rv = sensor_raw;
      sv = '0;
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 7) == 0) rv[i] = ~rv[i];
        if ($urandom_range(0, 5) == 0) sv[i] = 1'b1;
      end
      sensor_raw = rv;
      serve = sv;
      @(posedge clk_in);
      model_edge(rv, sv);
      @(negedge clk_in);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
